if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage for the MIPS pipeline. It generates the PC, issues one request per cycle to a synchronous instruction memory, and buffers returned instructions with their PC and PC+4 in a DEPTH-entry prefetch queue. The queue drains to decode over a valid/ready handshake. A branch redirect flushes the queue and any in-flight fetch, then restarts fetch at the branch target. It replaces the single-register fetch path with stall tolerance and prefetch.

---
 rtl/if_fetch_queue.sv | 101 ++++++++++
 tb/tb_if_fetch_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// The PC drives a synchronous instruction memory. Each returned instruction
// is queued together with its PC and handed to decode over valid/ready.
// A branch redirect flushes the queue and any fetch still in flight.
module if_fetch_queue #(
  parameter int                 WIDTH    = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       imem_en,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic [WIDTH-1:0]           imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_instr,
  output logic [WIDTH-1:0]           out_pc,
  output logic [WIDTH-1:0]           out_pc_plus4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] inflight_pc_reg;
  logic             inflight_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  logic [CW:0]      used_slots;
  logic             issue;
  logic             push;
  logic             pop;

  // Credit check counts the in-flight request as occupied. A pop in this
  // cycle is deliberately not counted, which keeps this path free of out_ready.
  always_comb begin
    used_slots = {1'b0, count_reg} + (CW+1)'(inflight_reg);
    issue      = rst && !redirect && (used_slots < (CW+1)'(DEPTH));
    push       = inflight_reg && !redirect;
    pop        = (count_reg != '0) && out_ready && !redirect;
  end

  assign imem_en      = issue;
  assign imem_addr    = pc_reg;
  assign out_valid    = (count_reg != '0);
  assign out_instr    = instr_mem[rd_ptr_reg];
  assign out_pc       = pc_mem[rd_ptr_reg];
  assign out_pc_plus4 = pc_mem[rd_ptr_reg] + WIDTH'(4);
  assign count        = count_reg;

  // PC, in-flight tracking and queue pointers; redirect overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (redirect) begin
      pc_reg       <= redirect_pc;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (issue) begin
        pc_reg          <= pc_reg + WIDTH'(4);
        inflight_reg    <= 1'b1;
        inflight_pc_reg <= pc_reg;
      end else begin
        inflight_reg    <= 1'b0;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Queue storage has no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: scoreboard of issued fetch addresses compared
// against every accepted output, plus directed timing checks.
module tb_if_fetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst, redirect, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_instr, out_pc, out_pc_plus4;
  logic        imem_en, out_valid;
  logic [2:0]  count;

  logic        rst_b, redirect_b, out_ready_b;
  logic [31:0] redirect_pc_b, imem_addr_b, imem_rdata_b, out_instr_b, out_pc_b, out_pc_plus4_b;
  logic        imem_en_b, out_valid_b;
  logic [2:0]  count_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  logic        s_en, s_valid;
  logic [31:0] s_addr, s_pc, s_instr, s_p4;
  logic [2:0]  s_count;
  logic [31:0] s_pc_b, s_instr_b, s_p4_b;

  always #5 clk = ~clk;

  if_fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .count(count)
  );

  if_fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFFFFF8)) dut_b (
    .clk(clk), .rst(rst_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
    .imem_en(imem_en_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b),
    .out_pc(out_pc_b), .out_pc_plus4(out_pc_plus4_b), .count(count_b)
  );

  // Synchronous instruction memory model: data = address ^ KEY, one cycle later.
  always @(posedge clk) begin
    imem_rdata   <= imem_addr ^ KEY;
    imem_rdata_b <= imem_addr_b ^ KEY;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sample one cycle at the falling edge, run the scoreboard, then pass the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    s_en = imem_en; s_addr = imem_addr; s_valid = out_valid; s_count = count;
    s_pc = out_pc; s_instr = out_instr; s_p4 = out_pc_plus4;
    s_pc_b = out_pc_b; s_instr_b = out_instr_b; s_p4_b = out_pc_plus4_b;
    if (!rst) begin
      exp_q.delete();
    end else if (redirect) begin
      check("redirect_en", 32'(imem_en), 32'd0);
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_pc", out_pc, e);
          check("sb_instr", out_instr, e ^ KEY);
          check("sb_pc4", out_pc_plus4, e + 32'd4);
          $display("out pc=%08h instr=%08h pc4=%08h", out_pc, out_instr, out_pc_plus4);
        end
      end
      if (imem_en) exp_q.push_back(imem_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    check("rst_en", 32'(s_en), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_count", 32'(s_count), 32'd0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    redirect_b = 1'b0; redirect_pc_b = '0; out_ready_b = 1'b1;
    #2;
    rst_b = 1'b0;

    // Streaming after reset release
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stream_en", 32'(s_en), 32'd1);
      check("stream_addr", s_addr, 32'(4 * i));
      check("stream_valid", 32'(s_valid), (i >= 2) ? 32'd1 : 32'd0);
      if (i == 2) begin
        check("first_pc", s_pc, 32'h0);
        check("first_pc4", s_p4, 32'h4);
      end
    end

    // Redirect coincident with a handshake
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    check("coinc_valid", 32'(s_valid), 32'd1);
    check("coinc_en", 32'(s_en), 32'd0);
    redirect = 1'b0;
    tick();
    check("coinc_count", 32'(s_count), 32'd0);
    check("coinc_flush_valid", 32'(s_valid), 32'd0);
    check("coinc_addr", s_addr, 32'h200);
    tick();
    tick();
    check("coinc_head_valid", 32'(s_valid), 32'd1);
    check("coinc_head_pc", s_pc, 32'h200);

    // Backpressure from reset
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bp_en", 32'(s_en), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) check("bp_addr", s_addr, 32'(4 * i));
    end
    check("bp_full_count", 32'(s_count), 32'd4);
    out_ready = 1'b1;
    tick();
    check("bp_pop_en", 32'(s_en), 32'd0);
    check("bp_head_pc", s_pc, 32'h0);
    tick();
    check("bp_resume_en", 32'(s_en), 32'd1);
    check("bp_resume_addr", s_addr, 32'h10);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bp_no_gap", 32'(s_valid), 32'd1);
    end

    // Redirect with two entries queued and one in flight
    out_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    check("rd_pre_count", 32'(s_count), 32'd2);
    redirect = 1'b0; out_ready = 1'b1;
    tick();
    check("rd_count", 32'(s_count), 32'd0);
    check("rd_valid", 32'(s_valid), 32'd0);
    check("rd_en", 32'(s_en), 32'd1);
    check("rd_addr", s_addr, 32'h100);
    tick();
    check("rd_valid_t2", 32'(s_valid), 32'd0);
    tick();
    check("rd_valid_t3", 32'(s_valid), 32'd1);
    check("rd_pc_t3", s_pc, 32'h100);
    for (int i = 0; i < 5; i++) tick();

    // Reset asserted mid-stream with a full queue
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    check("mid_full_count", 32'(s_count), 32'd4);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_en", 32'(imem_en), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    tick();
    tick();
    rst = 1'b1; out_ready = 1'b1;
    tick();
    check("mid_restart_en", 32'(s_en), 32'd1);
    check("mid_restart_addr", s_addr, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    // PC wrap-around on the second instance
    tick();
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) begin
        check("wrap_pc0", s_pc_b, 32'hFFFFFFF8);
        check("wrap_pc4_0", s_p4_b, 32'hFFFFFFFC);
        check("wrap_instr0", s_instr_b, 32'hFFFFFFF8 ^ KEY);
      end else if (i == 3) begin
        check("wrap_pc1", s_pc_b, 32'hFFFFFFFC);
        check("wrap_pc4_1", s_p4_b, 32'h0);
      end else if (i == 4) begin
        check("wrap_pc2", s_pc_b, 32'h0);
        check("wrap_pc4_2", s_p4_b, 32'h4);
        check("wrap_instr2", s_instr_b, 32'h0 ^ KEY);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
